// File: rtl/ifetch_unit.sv
// Instruction fetch front end: owns the PC, fetches from a combinational
// instruction memory and buffers {pc, instruction} pairs for decode.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic [31:0]                       instruction_addr,
  input  logic [31:0]                       instruction,
  input  logic                              redirect_valid,
  input  logic [31:0]                       redirect_pc,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [31:0]                       out_instr,
  output logic [31:0]                       out_pc,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [31:0]   r_pc;
  logic [31:0]   r_mem_pc    [FIFO_DEPTH];
  logic [31:0]   r_mem_instr [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic [CW-1:0]         w_count_next;
  logic [FIFO_DEPTH-1:0] w_we;

  assign w_full    = (r_count == DEPTH_C);
  // A redirect cycle neither hands out nor fetches anything.
  assign out_valid = (r_count != '0) & ~redirect_valid;
  assign w_pop     = out_valid & out_ready;
  assign w_push    = ~redirect_valid & (~w_full | w_pop);

  assign instruction_addr = r_pc;
  assign fifo_count       = r_count;
  assign out_pc           = r_mem_pc[r_rptr];
  assign out_instr        = r_mem_instr[r_rptr];

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_we
      assign w_we[gi] = w_push & (r_wptr == PW'(gi));
    end
  endgenerate

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (redirect_valid) begin
      // Low address bits are masked so the redirect target stays word aligned.
      r_pc    <= redirect_pc & 32'hFFFF_FFFC;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_pc   <= r_pc + 32'd4;
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_count <= w_count_next;
    end
  end

  // Entries are cleared on reset so the head reads zero until the first fetch lands.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (rst) begin
        r_mem_pc[i]    <= '0;
        r_mem_instr[i] <= '0;
      end else if (w_we[i]) begin
        r_mem_pc[i]    <= r_pc;
        r_mem_instr[i] <= instruction;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed, table-driven check of ifetch_unit against hand-computed cycle
// expectations; the memory model returns 32'h1000_0000 + address.
module tb_ifetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] instruction_addr;
  logic [31:0] instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  ifetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .instruction_addr (instruction_addr),
    .instruction      (instruction),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instr        (out_instr),
    .out_pc           (out_pc),
    .fifo_count       (fifo_count)
  );

  assign instruction = 32'h1000_0000 + instruction_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dkind: 0 = data not checked, 1 = head from memory model, 2 = head reads zero
  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic [31:0] addr;
    logic        vld;
    logic [2:0]  cnt;
    int          dkind;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rv, input logic [31:0] rpc,
                     input logic rdy, input logic [31:0] addr, input logic vld,
                     input logic [2:0] cnt, input int dkind, input logic [31:0] pc);
    vec_t v;
    v.rst = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.addr = addr;
    v.vld = vld; v.cnt = cnt; v.dkind = dkind; v.pc = pc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    // 1. free run after reset
    add(0,0,0,1, 32'h0,  0,0,2, 32'h0);
    add(0,0,0,1, 32'h4,  1,1,1, 32'h0);
    add(0,0,0,1, 32'h8,  1,1,1, 32'h4);
    add(0,0,0,1, 32'hC,  1,1,1, 32'h8);
    add(1,0,0,1, 32'h10, 1,1,1, 32'hC);
    // 2. backpressure for 10 cycles
    add(0,0,0,0, 32'h0,  0,0,2, 32'h0);
    add(0,0,0,0, 32'h4,  1,1,1, 32'h0);
    add(0,0,0,0, 32'h8,  1,2,1, 32'h0);
    add(0,0,0,0, 32'hC,  1,3,1, 32'h0);
    for (int i = 0; i < 6; i++) add(0,0,0,0, 32'h10, 1,4,1, 32'h0);
    // drain while refilling, count stays full
    add(0,0,0,1, 32'h10, 1,4,1, 32'h0);
    add(0,0,0,1, 32'h14, 1,4,1, 32'h4);
    add(0,0,0,1, 32'h18, 1,4,1, 32'h8);
    add(0,0,0,1, 32'h1C, 1,4,1, 32'hC);
    // 3. single pop while full
    add(0,0,0,0, 32'h20, 1,4,1, 32'h10);
    add(0,0,0,1, 32'h20, 1,4,1, 32'h10);
    add(0,0,0,0, 32'h24, 1,4,1, 32'h14);
    // 4. redirect with full FIFO
    add(0,1,32'h103,1, 32'h24, 0,4,0, 32'h0);
    add(0,0,0,1, 32'h100, 0,0,0, 32'h0);
    add(0,0,0,1, 32'h104, 1,1,1, 32'h100);
    // 5. wrap-around
    add(0,1,32'hFFFF_FFF8,1, 32'h108, 0,1,0, 32'h0);
    add(0,0,0,1, 32'hFFFF_FFF8, 0,0,0, 32'h0);
    add(0,0,0,1, 32'hFFFF_FFFC, 1,1,1, 32'hFFFF_FFF8);
    add(0,0,0,1, 32'h0,         1,1,1, 32'hFFFF_FFFC);
    add(0,0,0,1, 32'h4,         1,1,1, 32'h0);
    add(0,0,0,1, 32'h8,         1,1,1, 32'h4);
    // 6. reset together with redirect while count=3
    add(0,0,0,0, 32'hC,  1,1,1, 32'h8);
    add(0,0,0,0, 32'h10, 1,2,1, 32'h8);
    add(1,1,32'h40,0, 32'h14, 0,3,0, 32'h0);
    add(0,0,0,0, 32'h0,  0,0,2, 32'h0);
    // back-to-back redirects: last one wins
    add(0,1,32'h200,0, 32'h4,   0,1,0, 32'h0);
    add(0,1,32'h301,0, 32'h200, 0,0,0, 32'h0);
    add(0,0,0,1, 32'h300, 0,0,0, 32'h0);
    add(0,0,0,1, 32'h304, 1,1,1, 32'h300);

    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; redirect_valid = vecs[i].rv;
      redirect_pc = vecs[i].rpc; out_ready = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d addr", i), instruction_addr, vecs[i].addr);
      chk($sformatf("v%0d valid", i), {31'b0, out_valid}, {31'b0, vecs[i].vld});
      chk($sformatf("v%0d count", i), {29'b0, fifo_count}, {29'b0, vecs[i].cnt});
      if (vecs[i].dkind == 1) begin
        chk($sformatf("v%0d out_pc", i), out_pc, vecs[i].pc);
        chk($sformatf("v%0d out_instr", i), out_instr, 32'h1000_0000 + vecs[i].pc);
      end else if (vecs[i].dkind == 2) begin
        chk($sformatf("v%0d out_pc_zero", i), out_pc, 32'h0);
        chk($sformatf("v%0d out_instr_zero", i), out_instr, 32'h0);
      end
    end

    // Head entry must hold steady under backpressure while the FIFO fills.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
      #1;
      chk($sformatf("stall%0d out_pc", k), out_pc, 32'h304);
      chk($sformatf("stall%0d out_instr", k), out_instr, 32'h1000_0304);
      chk($sformatf("stall%0d count", k), {29'b0, fifo_count}, 32'(k + 1));
      chk($sformatf("stall%0d addr", k), instruction_addr, 32'h308 + 32'(4 * k));
    end

    // Drain in order; bounded wait for entry 0x310.
    begin
      logic [31:0] exp_pc;
      logic        seen;
      exp_pc = 32'h304;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk($sformatf("drain%0d out_pc", k), out_pc, exp_pc);
        if (out_pc == 32'h310) seen = 1'b1;
        exp_pc = exp_pc + 32'd4;
      end
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL drain_timeout: got no out_pc 00000310, expected it within 10 cycles");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
